// File: rtl/svga_timing_gen.sv
// ---------------------------------------------------------------------------
// svga_timing_gen
//
// 800x600@56 Hz SVGA timing generator for the 36 MHz pixel clock.
// Produces the pixel coordinates for the game renderer. The renderer's
// pipelined RGB is re-aligned with sync and blanking that have been delayed
// by PIPE_DELAY cycles. The VGA pins are then registered once more, so every
// pin lags its coordinate by PIPE_DELAY+1 cycles. The block also provides a
// frame-start pulse and a 16-bit completed-frame counter.
//
// Optional feature (macro SVGA_TEST_PATTERN_EN): when the macro is defined and
// test_mode=1, the RGB source is replaced by 8 vertical colour bars, each
// 100 px wide. The bar index comes from the delayed h coordinate. When the
// macro is undefined, test_mode is ignored.
//
// Ports:
//   pixel_clk    in   pixel clock
//   rst_n        in   synchronous active-low reset
//   red_in       in   [3:0] renderer red   (PIPE_DELAY cycles after coordinate)
//   green_in     in   [3:0] renderer green
//   blue_in      in   [3:0] renderer blue
//   test_mode    in   colour-bar select (only with SVGA_TEST_PATTERN_EN)
//   h_coord      out  [10:0] horizontal counter 0..H_TOTAL-1
//   v_coord      out  [9:0]  vertical counter 0..V_TOTAL-1
//   display_on   out  undelayed active-video flag
//   frame_start  out  high while counters are at (0,0)
//   frame_cnt    out  [15:0] completed frames, modulo 2^16
//   vga_hs       out  horizontal sync pin
//   vga_vs       out  vertical sync pin
//   vga_r/g/b    out  [3:0] colour pins, zero during blanking
//
// PIPE_DELAY must lie in 0..4.
// ---------------------------------------------------------------------------
module svga_timing_gen #(
    parameter int unsigned H_ACTIVE   = 800,
    parameter int unsigned H_FP       = 24,
    parameter int unsigned H_SYNC     = 72,
    parameter int unsigned H_BP       = 128,
    parameter int unsigned V_ACTIVE   = 600,
    parameter int unsigned V_FP       = 1,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 22,
    parameter bit          HS_POL     = 1'b1,
    parameter bit          VS_POL     = 1'b1,
    parameter int unsigned PIPE_DELAY = 1
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic [3:0]  red_in,
    input  logic [3:0]  green_in,
    input  logic [3:0]  blue_in,
    input  logic        test_mode,
    output logic [10:0] h_coord,
    output logic [9:0]  v_coord,
    output logic        display_on,
    output logic        frame_start,
    output logic [15:0] frame_cnt,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sums are formed at full integer width, then cast to the compare widths.
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // One delay-line tap. The h coordinate is carried along only when the
    // colour bars need it.
    typedef struct packed {
`ifdef SVGA_TEST_PATTERN_EN
        logic [10:0] h;
`endif
        logic        hs;
        logic        vs;
        logic        de;
    } tap_t;

    localparam tap_t TAP_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, default: '0};

    // ------------------------------------------------------------------
    // Coordinate counters and frame counter
    // ------------------------------------------------------------------
    logic [10:0] h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic        h_end, v_end;

    always_comb begin
        h_end  = (h_q == H_LAST);
        v_end  = (v_q == V_LAST);
        h_d    = h_end ? 11'd0 : h_q + 11'd1;
        v_d    = v_q;
        fcnt_d = fcnt_q;
        if (h_end) begin
            v_d = v_end ? 10'd0 : v_q + 10'd1;
            if (v_end) begin
                fcnt_d = fcnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            h_q    <= '0;
            v_q    <= '0;
            fcnt_q <= '0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign h_coord     = h_q;
    assign v_coord     = v_q;
    assign frame_cnt   = fcnt_q;
    assign display_on  = (h_q < H_ACT) && (v_q < V_ACT);
    assign frame_start = (h_q == 11'd0) && (v_q == 10'd0);

    // ------------------------------------------------------------------
    // Raw sync/enable decode. The polarity is applied here, so that the
    // delay line always holds pin levels.
    // ------------------------------------------------------------------
    tap_t tap_raw, tap_dly;

    always_comb begin
        tap_raw    = TAP_IDLE;
        tap_raw.hs = ((h_q >= HS_FIRST) && (h_q <= HS_LAST)) ? HS_POL : ~HS_POL;
        tap_raw.vs = ((v_q >= VS_FIRST) && (v_q <= VS_LAST)) ? VS_POL : ~VS_POL;
        tap_raw.de = display_on;
`ifdef SVGA_TEST_PATTERN_EN
        tap_raw.h  = h_q;
`endif
    end

    // ------------------------------------------------------------------
    // Delay line matching the renderer latency
    // ------------------------------------------------------------------
    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign tap_dly = tap_raw;
        end else begin : g_delay
            tap_t pipe_q [PIPE_DELAY];

            always_ff @(posedge pixel_clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(PIPE_DELAY); i++) begin
                        pipe_q[i] <= TAP_IDLE;
                    end
                end else begin
                    pipe_q[0] <= tap_raw;
                    for (int i = 1; i < int'(PIPE_DELAY); i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign tap_dly = pipe_q[PIPE_DELAY-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // RGB source selection
    // ------------------------------------------------------------------
    logic [11:0] rgb_src;

`ifdef SVGA_TEST_PATTERN_EN
    logic [10:0] bar_div;
    logic [2:0]  bar;
    logic [7:0]  unused_bar_hi;

    // Beyond pixel 799 the quotient exceeds 7, but blanking masks those
    // pixels, so only the low three bits matter.
    assign bar_div       = tap_dly.h / 11'd100;
    assign bar           = bar_div[2:0];
    assign unused_bar_hi = bar_div[10:3];

    always_comb begin
        rgb_src = {red_in, green_in, blue_in};
        if (test_mode) begin
            rgb_src = {{4{bar[0]}}, {4{bar[1]}}, {4{bar[2]}}};
        end
    end
`else
    logic unused_test_mode;

    assign unused_test_mode = test_mode;

    always_comb begin
        rgb_src = {red_in, green_in, blue_in};
    end
`endif

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic        hs_q, vs_q;
    logic [11:0] rgb_q;

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            rgb_q <= '0;
        end else begin
            hs_q  <= tap_dly.hs;
            vs_q  <= tap_dly.vs;
            rgb_q <= tap_dly.de ? rgb_src : 12'd0;
        end
    end

    assign vga_hs = hs_q;
    assign vga_vs = vs_q;
    assign vga_r  = rgb_q[11:8];
    assign vga_g  = rgb_q[7:4];
    assign vga_b  = rgb_q[3:0];

endmodule

// File: tb/tb_svga_timing_gen.sv
// Bench for svga_timing_gen.
// Instance A uses the full 800x600 timing with PIPE_DELAY=1. It covers reset,
// hsync timing, line blanking and the colour bars. A full frame is too long
// to simulate, so frame-level behaviour runs on instance B.
// Instance B uses a shrunken raster and PIPE_DELAY=2:
//   16 + 2 + 4 + 10 = 32 cycles per line, 8 + 1 + 2 + 3 = 14 lines per frame.
// On B, hsync pins are high for h in 21..24, and vsync spans (v9,h3)..(v11,h2).
// The renderer model for B returns red_in = h[3:0] two cycles late.
module tb_svga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A
    logic        rst_a, tm_a;
    logic [3:0]  ri_a, gi_a, bi_a;
    logic [10:0] h_a;
    logic [9:0]  v_a;
    logic        de_a, fs_a, hs_a, vs_a;
    logic [15:0] fc_a;
    logic [3:0]  r_a, g_a, b_a;

    // instance B
    logic        rst_b, tm_b;
    logic [3:0]  ri_b, gi_b, bi_b;
    logic [10:0] h_b;
    logic [9:0]  v_b;
    logic        de_b, fs_b, hs_b, vs_b;
    logic [15:0] fc_b;
    logic [3:0]  r_b, g_b, b_b;

    svga_timing_gen dut_a (
        .pixel_clk(clk), .rst_n(rst_a),
        .red_in(ri_a), .green_in(gi_a), .blue_in(bi_a), .test_mode(tm_a),
        .h_coord(h_a), .v_coord(v_a), .display_on(de_a), .frame_start(fs_a),
        .frame_cnt(fc_a), .vga_hs(hs_a), .vga_vs(vs_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
    );

    svga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(10),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .PIPE_DELAY(2)
    ) dut_b (
        .pixel_clk(clk), .rst_n(rst_b),
        .red_in(ri_b), .green_in(gi_b), .blue_in(bi_b), .test_mode(tm_b),
        .h_coord(h_b), .v_coord(v_b), .display_on(de_b), .frame_start(fs_b),
        .frame_cnt(fc_b), .vga_hs(hs_b), .vga_vs(vs_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
    );

    // Renderer model for B: two-cycle latency from coordinate to red.
    logic [3:0] rp1, rp2;
    always @(posedge clk) begin
        rp1 <= h_b[3:0];
        rp2 <= rp1;
    end
    assign ri_b = rp2;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_a(input int h_target, input int budget);
        int found = 0;
        for (int i = 0; i < budget && found == 0; i++) begin
            step();
            if (h_a == 11'(h_target)) found = 1;
        end
        chk("wait_a", found, 1);
    endtask

    int prev_hs, nrise, rise1_c, rise1_h, rise2_c, hs_w, w1, nfall, on_cnt, bad;
    int last_fs, n_fs, prev_vs, vs_run, n_vs, r_bad, g_bad, hsb_bad, vsb_bad;
    int found;
    logic [3:0] exp_r, exp_g;
    logic       act_b, exp_hs, exp_vs;

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; tm_a = 1'b0; tm_b = 1'b0;
        ri_a = 4'hF; gi_a = 4'hF; bi_a = 4'hF;
        gi_b = 4'hF; bi_b = 4'hF;

        // ---------------- reset on A ----------------
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_h", h_a, 0);
            chk("rst_v", v_a, 0);
            chk("rst_hs", hs_a, 0);
            chk("rst_vs", vs_a, 0);
            chk("rst_rgb", {r_a, g_a, b_a}, 0);
            chk("rst_fcnt", fc_a, 0);
        end
        rst_a = 1'b1;
        chk("fs_first", fs_a, 1);
        step();
        chk("h_after1", h_a, 1);
        chk("fs_gone", fs_a, 0);

        // ---------------- two lines: hsync and blanking ----------------
        prev_hs = 0; nrise = 0; rise1_c = 0; rise1_h = 0; rise2_c = 0;
        hs_w = 0; w1 = 0; nfall = 0; on_cnt = 0; bad = 0;
        for (int c = 0; c < 2048; c++) begin
            step();
            if (hs_a && prev_hs == 0) begin
                if (nrise == 0) begin
                    rise1_c = c;
                    rise1_h = int'(h_a);
                end else if (nrise == 1) begin
                    rise2_c = c;
                end
                nrise++;
                hs_w = 0;
            end
            if (hs_a) hs_w++;
            if (!hs_a && prev_hs == 1 && nfall == 0) begin
                w1 = hs_w;
                nfall++;
            end
            if ({r_a, g_a, b_a} == 12'hFFF) on_cnt++;
            else if ({r_a, g_a, b_a} != 12'h000) bad++;
            prev_hs = int'(hs_a);
        end
        chk("hs_rises", nrise, 2);
        chk("hs_rise_h", rise1_h, 826);
        chk("hs_width", w1, 72);
        chk("hs_period", rise2_c - rise1_c, 1024);
        chk("rgb_on_cycles", on_cnt, 1600);
        chk("rgb_partial", bad, 0);
        chk("pos_v", v_a, 2);
        chk("pos_h", h_a, 1);
        chk("display_on_act", de_a, 1);

        // ---------------- colour bars (or renderer passthrough) ----------------
        tm_a = 1'b1;
        wait_a(101, 2000);
`ifdef SVGA_TEST_PATTERN_EN
        chk("bar0_px99", {r_a, g_a, b_a}, 12'h000);
`else
        chk("tm_ignored_px99", {r_a, g_a, b_a}, 12'hFFF);
`endif
        step();
`ifdef SVGA_TEST_PATTERN_EN
        chk("bar1_px100", {r_a, g_a, b_a}, 12'hF00);
`else
        chk("tm_ignored_px100", {r_a, g_a, b_a}, 12'hFFF);
`endif
        wait_a(252, 2000);
`ifdef SVGA_TEST_PATTERN_EN
        chk("bar2_px250", {r_a, g_a, b_a}, 12'h0F0);
`else
        chk("tm_ignored_px250", {r_a, g_a, b_a}, 12'hFFF);
`endif
        wait_a(801, 2000);
        chk("bar7_px799", {r_a, g_a, b_a}, 12'hFFF);
        step();
        chk("blank_px800", {r_a, g_a, b_a}, 12'h000);
        chk("display_off_h802", de_a, 0);
        tm_a = 1'b0;

        // ---------------- small raster: frames, vsync, alignment ----------------
        rst_b = 1'b1;
        chk("b_fs_first", fs_b, 1);
        chk("b_h0", h_b, 0);
        last_fs = 0; n_fs = 0; prev_vs = 0; vs_run = 0; n_vs = 0;
        r_bad = 0; g_bad = 0; hsb_bad = 0; vsb_bad = 0;
        for (int n = 1; n <= 1344; n++) begin
            step();
            if (fs_b) begin
                chk("fs_period", n - last_fs, 448);
                last_fs = n;
                n_fs++;
            end
            if (n == 447) chk("fcnt_before_wrap", fc_b, 0);
            if (n == 448) chk("fcnt_at_wrap", fc_b, 1);
            if (vs_b && prev_vs == 0) vs_run = 0;
            if (vs_b) vs_run++;
            if (!vs_b && prev_vs == 1) begin
                chk("vs_width", vs_run, 64);
                n_vs++;
            end
            prev_vs = int'(vs_b);

            act_b  = (v_b < 10'd8) && (h_b >= 11'd3) && (h_b <= 11'd18);
            exp_r  = act_b ? 4'(h_b - 11'd3) : 4'h0;
            exp_g  = act_b ? 4'hF : 4'h0;
            exp_hs = (h_b >= 11'd21) && (h_b <= 11'd24);
            exp_vs = (v_b == 10'd9 && h_b >= 11'd3) || (v_b == 10'd10) ||
                     (v_b == 10'd11 && h_b < 11'd3);
            if (r_b !== exp_r) r_bad++;
            if (g_b !== exp_g || b_b !== exp_g) g_bad++;
            if (hs_b !== exp_hs) hsb_bad++;
            if (vs_b !== exp_vs) vsb_bad++;
        end
        chk("fs_count", n_fs, 3);
        chk("vs_pulses", n_vs, 3);
        chk("fcnt_3", fc_b, 3);
        chk("align_red", r_bad, 0);
        chk("blank_gb", g_bad, 0);
        chk("b_hs_pattern", hsb_bad, 0);
        chk("b_vs_pattern", vsb_bad, 0);

        // ---------------- mid-frame reset on B, with hsync pin high ----------------
        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            step();
            if (v_b == 10'd5 && h_b == 11'd22) found = 1;
        end
        chk("wait_b", found, 1);
        chk("b_hs_before_rst", hs_b, 1);
        rst_b = 1'b0;
        step();
        chk("mid_rst_h", h_b, 0);
        chk("mid_rst_v", v_b, 0);
        chk("mid_rst_hs", hs_b, 0);
        chk("mid_rst_vs", vs_b, 0);
        chk("mid_rst_fcnt", fc_b, 0);
        chk("mid_rst_rgb", {r_b, g_b, b_b}, 0);
        rst_b = 1'b1;
        chk("mid_rst_fs", fs_b, 1);
        step();
        chk("mid_rst_h1", h_b, 1);
        chk("mid_rst_v1", v_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/svga_timing_gen.md
Name: svga_timing_gen

Overview:
- Generates 800x600@56 Hz SVGA timing from the 36 MHz pixel_clk.
- Drives the pixel coordinates consumed by the game renderer.
- Re-aligns the renderer's pipelined RGB with delayed sync and blanking, and drives the VGA connector pins.
- Also supplies a frame-start pulse and a frame counter for game logic.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 72, hsync width (pixels)
- H_BP, 128, horizontal back porch (pixels); H_TOTAL = 1024
- V_ACTIVE, 600, visible lines
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 22, vertical back porch (lines); V_TOTAL = 625
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level
- PIPE_DELAY, 1, renderer latency in cycles from coordinate to RGB; legal range 0..4

Ports:
- pixel_clk  in  1  pixel clock, 36 MHz
- rst_n  in  1  synchronous, active-low reset
- red_in  in  4  renderer red
- green_in  in  4  renderer green
- blue_in  in  4  renderer blue
- test_mode  in  1  selects the test pattern (see Optional Feature)
- h_coord  out  11  horizontal counter, 0..H_TOTAL-1
- v_coord  out  10  vertical counter, 0..V_TOTAL-1
- display_on  out  1  h_coord < H_ACTIVE && v_coord < V_ACTIVE (undelayed)
- frame_start  out  1  single-cycle pulse while h_coord==0 && v_coord==0
- frame_cnt  out  16  completed-frame counter
- vga_hs  out  1  horizontal sync to pin
- vga_vs  out  1  vertical sync to pin
- vga_r  out  4  red to pin
- vga_g  out  4  green to pin
- vga_b  out  4  blue to pin

Behaviour:
- Reset (rst_n=0 at a pixel_clk edge):
  - h_coord=0, v_coord=0, frame_cnt=0.
  - vga_hs=!HS_POL, vga_vs=!VS_POL, vga_r/g/b=0.
  - All delay-line stages cleared to the inactive sync level and de=0.
  - Reset asserted mid-frame restarts the frame at (0,0) on the next cycle; there is no partial-line completion.
- Counters (registered):
  - h_coord increments every cycle. At H_TOTAL-1 it wraps to 0 and v_coord increments.
  - v_coord wraps to 0 when h_coord==H_TOTAL-1 && v_coord==V_TOTAL-1.
  - Frame period is 1024*625 = 640000 cycles.
- frame_cnt increments, modulo 2^16, on the same cycle v_coord wraps; 0xFFFF wraps to 0x0000.
- frame_start is decoded from the registered counters. It is high in the first cycle after reset release.
- Raw sync and enable, decoded from the counters:
  - hs_raw is active for h_coord in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [824,895].
  - vs_raw is active for v_coord in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [601,602], across whole lines.
  - de_raw = display_on.
- Alignment:
  - A shift register delays hs_raw, vs_raw and de_raw by PIPE_DELAY cycles.
  - The output stage registers once more:
    - vga_hs <= delayed hs
    - vga_vs <= delayed vs
    - vga_r/g/b <= delayed de ? {red_in,green_in,blue_in} : 0
  - Total latency from coordinate to pin is PIPE_DELAY+1 cycles for all pin outputs.
  - RGB is forced to zero during blanking regardless of the inputs.
- Width rules:
  - Comparisons are unsigned at 11 bits horizontal and 10 bits vertical.
  - Counter sums are evaluated at full width with no truncation.

Optional Feature:
- Macro: SVGA_TEST_PATTERN_EN.
- Defined:
  - When test_mode=1, RGB inputs are replaced before the output stage by 8 vertical colour bars, each 100 px wide.
  - Bar index k = delayed h_coord/100, k in 0..7.
  - Colour per bar: r={4{k[0]}}, g={4{k[1]}}, b={4{k[2]}}.
  - Blanking, latency and sync are unchanged.
- Not defined:
  - test_mode is ignored and RGB always comes from the renderer inputs.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles, then release.
  - During reset: h=0, v=0, vga_hs=0, vga_vs=0, rgb=0, frame_cnt=0.
  - First cycle after release: frame_start=1.
- Hsync: run one line.
  - vga_hs is high for exactly 72 cycles.
  - Rising edge is PIPE_DELAY+1 cycles after h_coord==824.
  - Next rising edge follows 1024 cycles later.
- Frame: run 3 frames.
  - vsync is high for 2048 consecutive cycles per frame.
  - frame_start pulses are 640000 cycles apart.
  - frame_cnt reads 3 after the third wrap.
- Blanking: drive red_in=green_in=blue_in=4'hF constantly.
  - vga_r/g/b = F for 800 cycles per visible line, 0 elsewhere.
  - All outputs are 0 on lines 600..624.
- Alignment with PIPE_DELAY=2: renderer model returns red_in = h_coord[3:0] two cycles late.
  - vga_r at pixel h equals h[3:0] across one active line.
- Mid-frame reset: assert rst_n=0 at v=300, h=500 for 1 cycle.
  - Next cycle h=0, v=0; sync outputs inactive; frame_cnt=0.
- SVGA_TEST_PATTERN_EN with test_mode=1:
  - Pixel 250 shows r=0, g=F, b=0 (bar 2).
  - Pixel 799 shows r=F, g=F, b=F (bar 7).
